// File: rtl/csr_mc_pkg.sv
// Shared definitions for the multi-channel CSR file: address map, IRQ bit
// positions, start FSM states and configuration reset values.
package csr_mc_pkg;
    localparam logic [31:0] A_CTRL     = 32'h000;
    localparam logic [31:0] A_STATUS   = 32'h004;
    localparam logic [31:0] A_IRQ_STAT = 32'h008;
    localparam logic [31:0] A_IRQ_MASK = 32'h00C;
    localparam logic [31:0] A_CFG      = 32'h010;
    localparam logic [31:0] A_ID       = 32'h030;
    localparam logic [31:0] A_PERF     = 32'h040;
    localparam logic [31:0] A_RESULT   = 32'h100;
    localparam logic [31:0] A_DMA      = 32'h200;

    localparam int IRQ_DONE_TILE = 0;
    localparam int IRQ_ERR_CRC   = 1;
    localparam int IRQ_ERR_ILL   = 2;
    localparam int IRQ_ERR_ADDR  = 3;
    localparam int IRQ_DMA0      = 4;

    // Index of each configuration word inside the 8-word cfg block
    localparam int CFG_M = 0, CFG_N = 1, CFG_K = 2, CFG_TM = 3;
    localparam int CFG_TN = 4, CFG_TK = 5, CFG_SA = 6, CFG_SW = 7;

    localparam logic [7:0]  ID_VERSION     = 8'h02;
    localparam logic [31:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;
    localparam logic [31:0] F32_ONE        = 32'h3F80_0000;
    localparam logic [7:0][31:0] CFG_RST   = {F32_ONE, F32_ONE, 192'h0};

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } start_st_e;
endpackage

// File: rtl/csr_irq_ctrl.sv
// Sticky interrupt status with W1C clear (set wins), mask register and
// registered level interrupt output.
module csr_irq_ctrl
    import csr_mc_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk_gated,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] i_set,
    input  logic [N_SRC-1:0] i_clr,
    input  logic             i_mask_we,
    input  logic [N_SRC-1:0] i_mask_wdata,
    input  logic             i_irq_en,
    output logic [N_SRC-1:0] o_status,
    output logic [N_SRC-1:0] o_mask,
    output logic             o_irq
);
    logic [N_SRC-1:0] r_status;
    logic [N_SRC-1:0] r_mask;
    logic             r_irq;

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= '0;
            r_mask   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~i_clr) | i_set;
            if (i_mask_we) r_mask <= i_mask_wdata;
            r_irq    <= i_irq_en & |(r_status & r_mask);
        end
    end

    assign o_status = r_status;
    assign o_mask   = r_mask;
    assign o_irq    = r_irq;
endmodule

// File: rtl/csr_regfile_mc.sv
// Multi-channel CSR file: job config with queued start, DMA descriptors,
// result/perf windows and masked IRQs. Define CSR_SHADOW_EN for shadowed config.
module csr_regfile_mc
    import csr_mc_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int N_DMA_CH = 4,
    parameter int N_RESULT = 16,
    parameter int N_PERF   = 8
) (
    input  logic                  clk_gated,
    input  logic                  rst_n,
    input  logic                  i_csr_wen,
    input  logic                  i_csr_ren,
    input  logic [ADDR_W-1:0]     i_csr_addr,
    input  logic [31:0]           i_csr_wdata,
    output logic [31:0]           o_csr_rdata,
    output logic                  o_csr_rvalid,
    input  logic                  i_core_busy,
    input  logic                  i_core_done_tile_pulse,
    input  logic                  i_rx_crc_error,
    input  logic                  i_rx_illegal_cmd,
    input  logic [32*N_RESULT-1:0] i_result_data,
    input  logic [32*N_PERF-1:0]  i_perf_in,
    input  logic [N_DMA_CH-1:0]   i_dma_busy_in,
    input  logic [N_DMA_CH-1:0]   i_dma_done_in,
    input  logic [32*N_DMA_CH-1:0] i_dma_bytes_in,
    output logic                  o_start_pulse,
    output logic                  o_abort_pulse,
    output logic                  o_irq,
    output logic [31:0]           o_cfg_M,
    output logic [31:0]           o_cfg_N,
    output logic [31:0]           o_cfg_K,
    output logic [31:0]           o_cfg_Tm,
    output logic [31:0]           o_cfg_Tn,
    output logic [31:0]           o_cfg_Tk,
    output logic [31:0]           o_cfg_Sa,
    output logic [31:0]           o_cfg_Sw,
    output logic [32*N_DMA_CH-1:0] o_dma_src,
    output logic [32*N_DMA_CH-1:0] o_dma_dst,
    output logic [32*N_DMA_CH-1:0] o_dma_len,
    output logic [N_DMA_CH-1:0]   o_dma_start
);
    localparam int N_SRC = IRQ_DMA0 + N_DMA_CH;

    logic [31:0]                 w_a, w_rdata, r_rdata;
    logic                        r_rvalid, r_irq_en, r_start_pulse, r_abort_pulse;
    logic                        w_hit, w_ctrl_we, w_irqs_we, w_mask_we, w_err_addr;
    logic                        w_start_wr, w_abort_wr, w_eff_busy, w_dims_bad;
    logic                        w_fire, w_fsm_ill, w_dma_ill, w_cfg_drop;
    logic [7:0]                  w_cfg_sel, w_cfg_we;
    logic [N_DMA_CH-1:0]         w_ch_sel, w_src_we, w_dst_we, w_len_we, w_chc_we;
    logic [N_DMA_CH-1:0]         w_dma_go, r_dma_start;
    logic [N_DMA_CH-1:0][31:0]   r_src, r_dst, r_len;
    logic [N_RESULT-1:0][31:0]   r_res;
    logic [N_PERF-1:0][31:0]     w_perf;
    logic [7:0][31:0]            r_cfg, w_view;
    logic [N_SRC-1:0]            w_set, w_clr, w_irq_status, w_irq_mask;
    start_st_e                   r_state, w_state_nxt;
    logic                        w_unused;

    // Byte counts have no register in the map yet; address bits [1:0] are don't-care
    assign w_unused = ^{i_dma_bytes_in, i_csr_addr[1:0]};
    assign w_a      = 32'(i_csr_addr) & ~32'h3;
    assign w_perf   = i_perf_in;

    always_comb begin
        w_rdata   = RDATA_UNMAPPED;
        w_hit     = 1'b0;
        w_cfg_sel = '0;
        w_ch_sel  = '0;
        if (w_a == A_CTRL)     begin w_hit = 1'b1; w_rdata = {29'b0, r_irq_en, 2'b0}; end
        if (w_a == A_STATUS)   begin w_hit = 1'b1; w_rdata = {30'b0, r_state == ST_PENDING, i_core_busy}; end
        if (w_a == A_IRQ_STAT) begin w_hit = 1'b1; w_rdata = 32'(w_irq_status); end
        if (w_a == A_IRQ_MASK) begin w_hit = 1'b1; w_rdata = 32'(w_irq_mask); end
        if (w_a == A_ID) begin
            w_hit   = 1'b1;
            w_rdata = {ID_VERSION, 8'(N_PERF), 8'(N_RESULT), 8'(N_DMA_CH)};
        end
        for (int i = 0; i < 8; i++)
            if (w_a == A_CFG + 32'(4*i)) begin w_hit = 1'b1; w_cfg_sel[i] = 1'b1; w_rdata = w_view[i]; end
        for (int i = 0; i < N_PERF; i++)
            if (w_a == A_PERF + 32'(4*i)) begin w_hit = 1'b1; w_rdata = w_perf[i]; end
        for (int i = 0; i < N_RESULT; i++)
            if (w_a == A_RESULT + 32'(4*i)) begin w_hit = 1'b1; w_rdata = r_res[i]; end
        for (int c = 0; c < N_DMA_CH; c++)
            if (w_a[31:4] == A_DMA[31:4] + 28'(c)) begin
                w_hit       = 1'b1;
                w_ch_sel[c] = 1'b1;
                case (w_a[3:2])
                    2'd0:    w_rdata = r_src[c];
                    2'd1:    w_rdata = r_dst[c];
                    2'd2:    w_rdata = r_len[c];
                    default: w_rdata = {29'b0, w_irq_status[IRQ_DMA0+c], i_dma_busy_in[c], 1'b0};
                endcase
            end
    end

    assign w_ctrl_we  = i_csr_wen && (w_a == A_CTRL);
    assign w_irqs_we  = i_csr_wen && (w_a == A_IRQ_STAT);
    assign w_mask_we  = i_csr_wen && (w_a == A_IRQ_MASK);
    assign w_err_addr = i_csr_wen && !w_hit;
    assign w_cfg_we   = w_cfg_sel & {8{i_csr_wen}};
    assign w_src_we   = w_ch_sel & {N_DMA_CH{i_csr_wen && w_a[3:2] == 2'd0}};
    assign w_dst_we   = w_ch_sel & {N_DMA_CH{i_csr_wen && w_a[3:2] == 2'd1}};
    assign w_len_we   = w_ch_sel & {N_DMA_CH{i_csr_wen && w_a[3:2] == 2'd2}};
    assign w_chc_we   = w_ch_sel & {N_DMA_CH{i_csr_wen && w_a[3:2] == 2'd3}};
    assign w_dma_go   = w_chc_we & {N_DMA_CH{i_csr_wdata[0]}} & ~i_dma_busy_in;
    assign w_dma_ill  = |(w_chc_we & {N_DMA_CH{i_csr_wdata[0]}} & i_dma_busy_in);

    // Abort in the same write as start suppresses the start
    assign w_abort_wr = w_ctrl_we && i_csr_wdata[1];
    assign w_start_wr = w_ctrl_we && i_csr_wdata[0] && !i_csr_wdata[1];
    assign w_eff_busy = i_core_busy | r_start_pulse;
    assign w_dims_bad = (w_view[CFG_TM] == '0) || (w_view[CFG_TN] == '0) || (w_view[CFG_TK] == '0);

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        w_fsm_ill   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_wr) begin
                    if (w_dims_bad)      w_fsm_ill   = 1'b1;
                    else if (w_eff_busy) w_state_nxt = ST_PENDING;
                    else                 w_fire      = 1'b1;
                end
            end
            default: begin
                if (w_abort_wr) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (w_start_wr) w_fsm_ill = 1'b1;
                    if (!w_eff_busy) begin
                        w_fire      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

`ifdef CSR_SHADOW_EN
    logic [7:0][31:0] r_shd;

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_shd <= CFG_RST;
            r_cfg <= CFG_RST;
        end else begin
            for (int i = 0; i < 8; i++)
                if (w_cfg_we[i]) r_shd[i] <= i_csr_wdata;
            if (w_fire) r_cfg <= r_shd;
        end
    end

    assign w_view     = r_shd;
    assign w_cfg_drop = 1'b0;
`else
    // Active config must not change under a running job
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= CFG_RST;
        end else if (!w_eff_busy) begin
            for (int i = 0; i < 8; i++)
                if (w_cfg_we[i]) r_cfg[i] <= i_csr_wdata;
        end
    end

    assign w_view     = r_cfg;
    assign w_cfg_drop = (|w_cfg_we) && w_eff_busy;
`endif

    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_irq_en      <= 1'b0;
            r_start_pulse <= 1'b0;
            r_abort_pulse <= 1'b0;
            r_dma_start   <= '0;
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_res         <= '0;
        end else begin
            r_rvalid      <= i_csr_ren;
            if (i_csr_ren) r_rdata <= w_rdata;
            if (w_ctrl_we) r_irq_en <= i_csr_wdata[2];
            r_start_pulse <= w_fire;
            r_abort_pulse <= w_abort_wr;
            r_dma_start   <= w_dma_go;
            for (int c = 0; c < N_DMA_CH; c++) begin
                if (w_src_we[c]) r_src[c] <= i_csr_wdata;
                if (w_dst_we[c]) r_dst[c] <= i_csr_wdata;
                if (w_len_we[c]) r_len[c] <= i_csr_wdata;
            end
            if (i_core_done_tile_pulse) r_res <= i_result_data;
        end
    end

    always_comb begin
        w_set                          = '0;
        w_set[IRQ_DONE_TILE]           = i_core_done_tile_pulse;
        w_set[IRQ_ERR_CRC]             = i_rx_crc_error;
        w_set[IRQ_ERR_ILL]             = i_rx_illegal_cmd | w_fsm_ill | w_dma_ill | w_cfg_drop;
        w_set[IRQ_ERR_ADDR]            = w_err_addr;
        w_set[IRQ_DMA0 +: N_DMA_CH]    = i_dma_done_in;
        w_clr = w_irqs_we ? i_csr_wdata[N_SRC-1:0] : '0;
        // Channel CTRL bit 2 is a W1C alias of that channel's done bit
        for (int c = 0; c < N_DMA_CH; c++)
            if (w_chc_we[c] && i_csr_wdata[2]) w_clr[IRQ_DMA0+c] = 1'b1;
    end

    csr_irq_ctrl #(.N_SRC(N_SRC)) u_irq (
        .clk_gated    (clk_gated),
        .rst_n        (rst_n),
        .i_set        (w_set),
        .i_clr        (w_clr),
        .i_mask_we    (w_mask_we),
        .i_mask_wdata (i_csr_wdata[N_SRC-1:0]),
        .i_irq_en     (r_irq_en),
        .o_status     (w_irq_status),
        .o_mask       (w_irq_mask),
        .o_irq        (o_irq)
    );

    assign o_csr_rdata   = r_rdata;
    assign o_csr_rvalid  = r_rvalid;
    assign o_start_pulse = r_start_pulse;
    assign o_abort_pulse = r_abort_pulse;
    assign o_dma_start   = r_dma_start;
    assign o_dma_src     = r_src;
    assign o_dma_dst     = r_dst;
    assign o_dma_len     = r_len;
    assign o_cfg_M       = r_cfg[CFG_M];
    assign o_cfg_N       = r_cfg[CFG_N];
    assign o_cfg_K       = r_cfg[CFG_K];
    assign o_cfg_Tm      = r_cfg[CFG_TM];
    assign o_cfg_Tn      = r_cfg[CFG_TN];
    assign o_cfg_Tk      = r_cfg[CFG_TK];
    assign o_cfg_Sa      = r_cfg[CFG_SA];
    assign o_cfg_Sw      = r_cfg[CFG_SW];
endmodule

// File: tb/tb_csr_regfile_mc.sv
// Directed bench for csr_regfile_mc; expectations follow CSR_SHADOW_EN when defined.
module tb_csr_regfile_mc;
    localparam int NC = 4, NR = 16, NP = 8;
`ifdef CSR_SHADOW_EN
    localparam bit SHD = 1'b1;
`else
    localparam bit SHD = 1'b0;
`endif

    logic            clk_gated = 1'b0, rst_n = 1'b0;
    logic            wen = 1'b0, ren = 1'b0;
    logic [9:0]      addr = '0;
    logic [31:0]     wdata = '0, rdata;
    logic            rvalid;
    logic            core_busy = 1'b0, done_tile = 1'b0, crc_err = 1'b0, ill_cmd = 1'b0;
    logic [32*NR-1:0] result_data;
    logic [32*NP-1:0] perf_in;
    logic [NC-1:0]   dma_busy = '0, dma_done = '0, dma_start;
    logic [32*NC-1:0] dma_bytes = '0, dma_src, dma_dst, dma_len;
    logic            start_pulse, abort_pulse, irq;
    logic [31:0]     cfg_M, cfg_N, cfg_K, cfg_Tm, cfg_Tn, cfg_Tk, cfg_Sa, cfg_Sw;
    logic            seen;
    int              checks = 0, errors = 0;

    always #5 clk_gated = ~clk_gated;

    csr_regfile_mc #(.ADDR_W(10), .N_DMA_CH(NC), .N_RESULT(NR), .N_PERF(NP)) dut (
        .clk_gated(clk_gated), .rst_n(rst_n),
        .i_csr_wen(wen), .i_csr_ren(ren), .i_csr_addr(addr), .i_csr_wdata(wdata),
        .o_csr_rdata(rdata), .o_csr_rvalid(rvalid),
        .i_core_busy(core_busy), .i_core_done_tile_pulse(done_tile),
        .i_rx_crc_error(crc_err), .i_rx_illegal_cmd(ill_cmd),
        .i_result_data(result_data), .i_perf_in(perf_in),
        .i_dma_busy_in(dma_busy), .i_dma_done_in(dma_done), .i_dma_bytes_in(dma_bytes),
        .o_start_pulse(start_pulse), .o_abort_pulse(abort_pulse), .o_irq(irq),
        .o_cfg_M(cfg_M), .o_cfg_N(cfg_N), .o_cfg_K(cfg_K), .o_cfg_Tm(cfg_Tm),
        .o_cfg_Tn(cfg_Tn), .o_cfg_Tk(cfg_Tk), .o_cfg_Sa(cfg_Sa), .o_cfg_Sw(cfg_Sw),
        .o_dma_src(dma_src), .o_dma_dst(dma_dst), .o_dma_len(dma_len), .o_dma_start(dma_start)
    );

    task automatic tick();
        @(posedge clk_gated);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic rdchk(input logic [9:0] a, input logic [31:0] exp, input string tag);
        ren = 1'b1; addr = a;
        tick();
        ren = 1'b0;
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk(tag, rdata, exp);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) result_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < NP; i++) perf_in[32*i +: 32]     = 32'h5000_0000 + 32'(i);

        // Reset values
        repeat (2) tick();
        chk("rst_start", 32'(start_pulse), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_sa", cfg_Sa, 32'h3F80_0000);
        chk("rst_sw", cfg_Sw, 32'h3F80_0000);
        chk("rst_m", cfg_M, 32'd0);
        chk("rst_dma_start", 32'(dma_start), 32'd0);
        rst_n = 1'b1;
        tick();

        rdchk(10'h030, 32'h0208_1004, "id");

        // Legal start with core idle
        wr(10'h01C, 4); wr(10'h020, 4); wr(10'h024, 4);
        chk("tm_before_start", cfg_Tm, SHD ? 32'd0 : 32'd4);
        wen = 1'b1; addr = 10'h000; wdata = 1;
        chk("start_same_cycle", 32'(start_pulse), 32'd0);
        tick();
        wen = 1'b0;
        chk("start_pulse", 32'(start_pulse), 32'd1);
        chk("tm_commit", cfg_Tm, 32'd4);
        tick();
        chk("start_single", 32'(start_pulse), 32'd0);

        // Queued start while busy
        core_busy = 1'b1;
        wr(10'h000, 1);
        chk("busy_nostart", 32'(start_pulse), 32'd0);
        rdchk(10'h004, 32'h3, "status_pending");
        wr(10'h010, 64);
        chk("m_busy_write", cfg_M, 32'd0);
        rdchk(10'h008, SHD ? 32'h0 : 32'h4, "cfg_busy_err");
        wr(10'h008, 32'hFF);
        wr(10'h000, 1);
        rdchk(10'h008, 32'h4, "second_start_err");
        wr(10'h008, 32'hFF);
        chk("pending_hold", 32'(start_pulse), 32'd0);
        core_busy = 1'b0;
        tick();
        chk("pending_fire", 32'(start_pulse), 32'd1);
        chk("m_commit", cfg_M, SHD ? 32'd64 : 32'd0);
        rdchk(10'h004, 32'h0, "status_idle");

        // Masked interrupt on DMA done
        wr(10'h00C, 32'h10);
        wr(10'h000, 4);
        dma_done = 4'b0001;
        tick();
        dma_done = '0;
        chk("irq_lat1", 32'(irq), 32'd0);
        tick();
        chk("irq_lat2", 32'(irq), 32'd1);
        wen = 1'b1; addr = 10'h008; wdata = 32'h10; dma_done = 4'b0001;
        tick();
        wen = 1'b0; dma_done = '0;
        rdchk(10'h008, 32'h10, "set_beats_clr");
        wr(10'h008, 32'h10);
        rdchk(10'h008, 32'h0, "w1c");
        chk("irq_drop", 32'(irq), 32'd0);
        dma_done = 4'b0010;
        tick();
        dma_done = '0;
        rdchk(10'h21C, 32'h4, "ch1_done_mirror");
        wr(10'h21C, 32'h4);
        rdchk(10'h008, 32'h0, "ch1_done_w1c");

        // Result capture and same-cycle read of a setting status bit
        rdchk(10'h10C, 32'h0, "result_pre");
        done_tile = 1'b1; ren = 1'b1; addr = 10'h008;
        tick();
        done_tile = 1'b0; ren = 1'b0;
        chk("read_preset", rdata, 32'h0);
        rdchk(10'h008, 32'h1, "done_tile_set");
        rdchk(10'h10C, 32'hA000_0003, "result3");
        wr(10'h008, 32'hFF);

        // Unmapped and out-of-range accesses
        rdchk(10'h3FC, 32'hDEAD_BEEF, "rd_unmapped");
        rdchk(10'h034, 32'hDEAD_BEEF, "rd_hole");
        rdchk(10'h064, 32'hDEAD_BEEF, "rd_perf_oor");
        rdchk(10'h240, 32'hDEAD_BEEF, "rd_ch_oor");
        rdchk(10'h048, 32'h5000_0002, "perf2");
        tick();
        chk("rvalid_pulse", 32'(rvalid), 32'd0);
        chk("rdata_hold", rdata, 32'h5000_0002);
        wr(10'h3FC, 32'h1234);
        rdchk(10'h008, 32'h8, "err_addr");
        wr(10'h008, 32'hFF);

        // DMA descriptors and starts
        wr(10'h220, 32'h1234);
        rdchk(10'h220, 32'h1234, "ch2_src_rd");
        chk("ch2_src_out", dma_src[95:64], 32'h1234);
        dma_busy = 4'b0100;
        wr(10'h22C, 1);
        chk("ch2_busy_nostart", 32'(dma_start), 32'd0);
        rdchk(10'h22C, 32'h2, "ch2_ctrl_busy");
        rdchk(10'h008, 32'h4, "dma_busy_err");
        wr(10'h008, 32'hFF);
        dma_busy = '0;
        wr(10'h21C, 1);
        chk("ch1_start", 32'(dma_start), 32'h2);
        tick();
        chk("ch1_start_single", 32'(dma_start), 32'd0);

        // Abort, and abort beating start
        wr(10'h000, 2);
        chk("abort", 32'(abort_pulse), 32'd1);
        wr(10'h000, 3);
        chk("abort_wins_abort", 32'(abort_pulse), 32'd1);
        chk("abort_wins_nostart", 32'(start_pulse), 32'd0);

        // Illegal dims
        wr(10'h024, 0);
        wr(10'h000, 1);
        chk("ill_nostart", 32'(start_pulse), 32'd0);
        rdchk(10'h008, 32'h4, "ill_dims");
        wr(10'h008, 32'hFF);
        wr(10'h024, 4);

        // Reset while a start is queued
        core_busy = 1'b1;
        wr(10'h000, 1);
        rdchk(10'h004, 32'h3, "pending_before_rst");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        core_busy = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | start_pulse;
        end
        chk("no_start_after_rst", 32'(seen), 32'd0);
        rdchk(10'h004, 32'h0, "status_after_rst");
        chk("sa_after_rst", cfg_Sa, 32'h3F80_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_regfile_mc.md
# csr_regfile_mc

Multi-channel control/status register file for the next-generation accelerator, sitting between the AXI4-Lite slave shim and the core/DMA engines. It generalises the single-job CSR block with parametrised DMA channel count, a parametrised result window and a parametrised perf-counter window. It adds a one-deep queued start, shadow configuration committed atomically at launch, and a masked interrupt controller. Reads return with registered one-cycle latency.

## Interface
- ADDR_W, 10, byte-address width (1 KiB map)
- N_DMA_CH, 4, DMA channels, 1..28
- N_RESULT, 16, 32-bit result capture registers, 1..64
- N_PERF, 8, 32-bit perf counter inputs, 1..16
- clk_gated  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- csr_wen, csr_ren  in  1  single-cycle access strobes, mutually exclusive
- csr_addr  in  ADDR_W  byte address; bits [1:0] ignored
- csr_wdata  in  32  write data
- csr_rdata  out  32  read data, valid when csr_rvalid
- csr_rvalid  out  1  one-cycle pulse, cycle after csr_ren
- core_busy, core_done_tile_pulse, rx_crc_error, rx_illegal_cmd  in  1  core events
- result_data  in  32*N_RESULT  results, word i at [32i+31:32i]
- perf_in  in  32*N_PERF  perf counters
- dma_busy_in, dma_done_in  in  N_DMA_CH  per-channel status; done is a pulse
- dma_bytes_in  in  32*N_DMA_CH  bytes transferred per channel
- start_pulse, abort_pulse  out  1  registered single-cycle pulses
- irq  out  1  registered level interrupt
- cfg_M, cfg_N, cfg_K, cfg_Tm, cfg_Tn, cfg_Tk, cfg_Sa, cfg_Sw  out  32  active configuration
- dma_src, dma_dst, dma_len  out  32*N_DMA_CH  per-channel descriptors
- dma_start  out  N_DMA_CH  registered per-channel start pulses

## Operation
- Map:
  - 0x000 CTRL: [0] start W1P, [1] abort W1P, [2] irq_en RW.
  - 0x004 STATUS RO: [0] core_busy, [1] start_pending.
  - 0x008 IRQ_STATUS R/W1C; 0x00C IRQ_MASK RW.
  - 0x010–0x02C M, N, K, Tm, Tn, Tk, Sa, Sw (shadow, RW).
  - 0x030 ID RO: {8'h02, N_PERF[7:0], N_RESULT[7:0], N_DMA_CH[7:0]}.
  - 0x040+4i perf i; 0x100+4i result i.
  - 0x200+0x10c channel c: SRC, DST, LEN (RW), CTRL ([0] start W1P, [1] busy RO, [2] done R/W1C mirror of IRQ_STATUS bit).
- Unmapped or out-of-range index: read returns 32'hDEAD_BEEF; write is ignored and sets err_addr.
- IRQ_STATUS bits: [0] done_tile, [1] err_crc, [2] err_illegal, [3] err_addr, [4+c] dma_done[c]. Unused upper bits read 0.
- Sticky setters beat a W1C clear in the same cycle (set wins).
- irq <= irq_en & |(IRQ_STATUS & IRQ_MASK).
- Start FSM, states IDLE, PENDING:
  - Effective busy is core_busy | start_pulse_q, the start issued the previous cycle.
  - Dims are illegal when any of Tm/Tn/Tk in shadow is 0.
  - IDLE, start write, not busy, legal: start_pulse next cycle and shadow→active commit on the same edge.
  - IDLE, start write while busy and legal: go to PENDING.
  - Illegal dims: set err_illegal, no pulse, stay in IDLE.
  - PENDING: first cycle effective busy is low → start_pulse plus commit, then IDLE.
  - PENDING, further start write: set err_illegal, stay PENDING.
  - Abort write, any state: abort_pulse next cycle; PENDING→IDLE.
  - Abort and start in the same write: abort wins, no start.
- DMA: channel start while dma_busy_in[c] sets err_illegal and issues no pulse. Descriptors are not shadowed.
- core_done_tile_pulse captures all result_data words.

## Timing
- Reset values: all outputs 0, except cfg_Sa/cfg_Sw, which reset to 32'h3F80_0000 (shadow copies too). State is IDLE.
- Write effect is visible on outputs at the edge after csr_wen. start_pulse, abort_pulse and dma_start all have 1-cycle latency.
- Read: csr_rdata and csr_rvalid are registered; csr_rdata holds its value until the next read.
- A read of IRQ_STATUS in the same cycle as a set returns the pre-set value.
- Reset mid-PENDING drops the queued start.

## Configuration
- CSR_SHADOW_EN defined: config writes land in shadow and copy to active only on a start commit, so the host may program the next job while busy.
- CSR_SHADOW_EN undefined: there is no shadow. Writes go straight to active, but a config write while effective busy is dropped and sets err_illegal. Reads return the active values.

## Structure
- Shared package csr_mc_pkg holds:
  - address localparams;
  - IRQ bit indices;
  - the start FSM state enum;
  - the ID version constant.
- Sub-module csr_irq_ctrl holds the sticky set/W1C logic, mask and irq register, and is parametrised by source count 4+N_DMA_CH.

## Test plan
- Write Tm=Tn=Tk=4, then CTRL=1 with core idle → start_pulse exactly 1 cycle after the write; cfg_Tm=4 on the same edge.
- core_busy=1, CTRL=1 → STATUS[1]=1. Drop busy → start_pulse on the first idle cycle and STATUS[1]=0. A second start while PENDING → IRQ_STATUS[2]=1.
- Write M=64 while busy with CSR_SHADOW_EN → cfg_M unchanged until the queued start commits, then 64. Without the macro, the write is dropped and err_illegal is set.
- IRQ_MASK=0x10, irq_en=1, pulse dma_done_in[0] → irq=1 two cycles later. W1C 0x10 on the same cycle as a new dma_done pulse → bit stays 1.
- Read 0x3FC → rdata 0xDEADBEEF with rvalid. Write 0x3FC → IRQ_STATUS[3]=1.
- Channel 2 CTRL=1 while dma_busy_in[2]=1 → no dma_start[2] and err_illegal is set. Apply rst_n low mid-PENDING → no start after reset release.
